// File: rtl/eth_tx_pkg.sv
// Shared definitions for the PHY transmit path: beat layout, arbiter states
// and default timing limits.
package eth_tx_pkg;

  localparam int BEAT_W               = 9;
  localparam int TX_EN_BIT            = 8;
  localparam int IFG_CYCLES_DEF       = 12;
  localparam int MAX_FRAME_CYCLES_DEF = 2048;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// Bundle of the two frame-source handshakes plus the PHY FIFO side.
// master = sources/PHY environment, slave = the arbiter.
interface phy_tx_arbiter_if;
  import eth_tx_pkg::*;

  logic              req0;
  logic              gnt0;
  logic              rdy0;
  logic [BEAT_W-1:0] din0;
  logic              wr_en0;
  logic              req1;
  logic              gnt1;
  logic              rdy1;
  logic [BEAT_W-1:0] din1;
  logic              wr_en1;
  logic [BEAT_W-1:0] phy_din;
  logic              phy_wr_en;
  logic              phy_full;
  logic [15:0]       frame_cnt;
  logic [7:0]        abort_cnt;

  modport master (
    output req0, din0, wr_en0, req1, din1, wr_en1, phy_full,
    input  gnt0, rdy0, gnt1, rdy1, phy_din, phy_wr_en, frame_cnt, abort_cnt
  );

  modport slave (
    input  req0, din0, wr_en0, req1, din1, wr_en1, phy_full,
    output gnt0, rdy0, gnt1, rdy1, phy_din, phy_wr_en, frame_cnt, abort_cnt
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; the pointer moves to the other source
// whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       vld,
  output logic       idx
);

  logic rr_q;

  always_comb begin
    vld = |req;
    idx = 1'b0;
    if (req == 2'b11) idx = rr_q;
    else              idx = req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)             rr_q <= 1'b0;
    else if (en && vld)  rr_q <= ~idx;
  end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the PHY TX FIFO, with
// inter-frame gap and a stuck-frame watchdog.
module phy_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int IFG_CYCLES       = IFG_CYCLES_DEF,
  parameter int MAX_FRAME_CYCLES = MAX_FRAME_CYCLES_DEF
) (
  input  logic             pcie_clk,
  input  logic             sys_rst,
  phy_tx_arbiter_if.slave  bus
);

  localparam int WD_W  = $clog2(MAX_FRAME_CYCLES) + 1;
  localparam int GAP_W = $clog2(IFG_CYCLES + 2);

  tx_state_e         state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              owner_q, owner_d;
  logic              started_q, started_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BEAT_W-1:0] beat_p0, beat_p1;
  logic              vld_p0, vld_p1;
  logic              frame_inc, abort_inc;
  logic [15:0]       frame_cnt_q;
  logic [7:0]        abort_cnt_q;

  logic [1:0]        rdy;
  logic              req_sel, wr_sel, acc, eof, started_now, wd_expired;
  logic [BEAT_W-1:0] din_sel;
  logic              arb_en, arb_vld, arb_idx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_rr (
    .clk (pcie_clk),
    .rst (sys_rst),
    .en  (arb_en),
    .req ({bus.req1, bus.req0}),
    .vld (arb_vld),
    .idx (arb_idx)
  );

  assign rdy         = gnt_q & {2{~bus.phy_full & (state_q == ST_XFER)}};
  assign req_sel     = owner_q ? bus.req1   : bus.req0;
  assign wr_sel      = owner_q ? bus.wr_en1 : bus.wr_en0;
  assign din_sel     = owner_q ? bus.din1   : bus.din0;
  assign acc         = wr_sel & rdy[owner_q];
  // Terminator only counts once the frame has actually started.
  assign eof         = acc & ~din_sel[TX_EN_BIT] & started_q;
  assign started_now = started_q | (acc & din_sel[TX_EN_BIT]);
  assign wd_expired  = (wd_q == WD_W'(MAX_FRAME_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    started_d = started_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    beat_p0   = '0;
    vld_p0    = 1'b0;
    frame_inc = 1'b0;
    abort_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          owner_d   = arb_idx;
          gnt_d     = arb_idx ? 2'b10 : 2'b01;
          wd_d      = '0;
          started_d = 1'b0;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        wd_d = wd_q + WD_W'(1);
        if (acc && din_sel[TX_EN_BIT]) begin
          beat_p0   = din_sel;
          vld_p0    = 1'b1;
          started_d = 1'b1;
        end
        if (eof) begin
          beat_p0   = din_sel;
          vld_p0    = 1'b1;
          gnt_d     = 2'b00;
          frame_inc = 1'b1;
          gap_d     = GAP_W'(IFG_CYCLES);
          state_d   = ST_GAP;
        end else if (wd_expired || (!req_sel && started_now)) begin
          // Forced terminator goes out even while the FIFO reports full.
          beat_p0   = '0;
          vld_p0    = 1'b1;
          gnt_d     = 2'b00;
          abort_inc = 1'b1;
          gap_d     = GAP_W'(IFG_CYCLES);
          state_d   = ST_GAP;
        end else if (!req_sel) begin
          gnt_d   = 2'b00;
          gap_d   = GAP_W'(IFG_CYCLES);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- p0 -> p1: state, counters and the registered PHY beat ----
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      owner_q     <= 1'b0;
      started_q   <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      beat_p1     <= '0;
      vld_p1      <= 1'b0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      started_q <= started_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      beat_p1   <= beat_p0;
      vld_p1    <= vld_p0;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (abort_inc) abort_cnt_q <= sat_inc8(abort_cnt_q);
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.rdy0      = rdy[0];
  assign bus.rdy1      = rdy[1];
  assign bus.phy_din   = beat_p1;
  assign bus.phy_wr_en = vld_p1;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: frames, round-robin order, stalls,
// watchdog/req-drop aborts, counter saturation and mid-frame reset.
module tb_phy_tx_arbiter;
  import eth_tx_pkg::*;

  localparam int IFG = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   wr_pulses = 0;

  phy_tx_arbiter_if bus ();
  phy_tx_arbiter_if bus_w ();

  phy_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(2048)) dut (
    .pcie_clk (clk),
    .sys_rst  (rst),
    .bus      (bus)
  );

  phy_tx_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME_CYCLES(64)) dut_w (
    .pcie_clk (clk),
    .sys_rst  (rst),
    .bus      (bus_w)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.phy_wr_en === 1'b1) wr_pulses++;
    vecs++;
    assert (!(bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1)) else begin
      errs++;
      $error("FAIL gnt_overlap observed=%0b%0b required=not both", bus.gnt0, bus.gnt1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic we, input logic [8:0] d);
    if (src == 0) begin bus.wr_en0 = we; bus.din0 = d; end
    else          begin bus.wr_en1 = we; bus.din1 = d; end
  endtask

  task automatic wait_gnt(input int maxc, output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < maxc) begin
      step();
      cyc++;
      if (bus.gnt0 === 1'b1)      who = 0;
      else if (bus.gnt1 === 1'b1) who = 1;
    end
    chk("gnt_seen", 32'(who >= 0), 32'd1);
  endtask

  // Sends nbytes tx_en=1 beats (base, base+1, ...) and optionally a
  // terminating {0,A5} beat; phy_full is raised for cycles [stall_at, stall_at+stall_len).
  task automatic send_frame(input int src, input int nbytes, input bit term,
                            input int stall_at, input int stall_len, input logic [7:0] base);
    int         sent;
    int         cyc;
    int         total;
    logic [8:0] beat;
    logic       acc;
    logic       other;
    sent  = 0;
    cyc   = 0;
    total = nbytes + (term ? 1 : 0);
    while (sent < total && cyc < 2000) begin
      beat = (sent < nbytes) ? {1'b1, 8'(base + 8'(sent))} : 9'h0A5;
      bus.phy_full = (cyc >= stall_at && cyc < stall_at + stall_len);
      drive(src, 1'b1, beat);
      #1;
      acc   = (src == 0) ? bus.rdy0 : bus.rdy1;
      other = (src == 0) ? bus.rdy1 : bus.rdy0;
      chk("rdy_ungranted", 32'(other), 32'd0);
      if (bus.phy_full) chk("rdy_stall", 32'(acc), 32'd0);
      step();
      if (acc === 1'b1) begin
        chk("phy_wr_en_acc", 32'(bus.phy_wr_en), 32'd1);
        chk("phy_din", 32'(bus.phy_din), 32'(beat));
        sent++;
      end else begin
        chk("phy_wr_en_idle", 32'(bus.phy_wr_en), 32'd0);
      end
      cyc++;
    end
    chk("send_done", 32'(sent), 32'(total));
    drive(src, 1'b0, 9'h000);
    bus.phy_full = 1'b0;
  endtask

  initial begin
    int who;
    int c;
    int n;
    int p0;
    bus.req0 = 0; bus.req1 = 0; bus.wr_en0 = 0; bus.wr_en1 = 0;
    bus.din0 = '0; bus.din1 = '0; bus.phy_full = 0;
    bus_w.req0 = 0; bus_w.req1 = 0; bus_w.wr_en0 = 0; bus_w.wr_en1 = 0;
    bus_w.din0 = '0; bus_w.din1 = '0; bus_w.phy_full = 0;

    // Reset state
    step(); step(); step();
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rdy0", 32'(bus.rdy0), 32'd0);
    chk("rst_rdy1", 32'(bus.rdy1), 32'd0);
    chk("rst_phy_din", 32'(bus.phy_din), 32'h000);
    chk("rst_phy_wr_en", 32'(bus.phy_wr_en), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_abort_cnt", 32'(bus.abort_cnt), 32'd0);
    rst = 1'b0;

    // Source 0 alone: 64 data beats plus terminator
    bus.req0 = 1'b1;
    wait_gnt(50, who, c);
    chk("t1_who", 32'(who), 32'd0);
    p0 = wr_pulses;
    send_frame(0, 64, 1'b1, 1000, 0, 8'h00);
    chk("t1_gnt0_fall", 32'(bus.gnt0), 32'd0);
    chk("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("t1_abort_cnt", 32'(bus.abort_cnt), 32'd0);
    step();
    chk("t1_pulses", 32'(wr_pulses - p0), 32'd65);

    // req0 still high through the gap: next grant no sooner than IFG+2
    wait_gnt(100, who, c);
    chk("t1_regrant_who", 32'(who), 32'd0);
    chk("t1_ifg_spacing", 32'(c + 1 >= IFG + 2), 32'd1);
    drive(0, 1'b1, 9'h055);
    step();
    chk("t1_drop_beat", 32'(bus.phy_wr_en), 32'd0);
    drive(0, 1'b0, 9'h000);
    bus.req0 = 1'b0;
    step();
    chk("t1_release_gnt", 32'(bus.gnt0), 32'd0);
    chk("t1_release_wr", 32'(bus.phy_wr_en), 32'd0);
    chk("t1_release_frames", 32'(bus.frame_cnt), 32'd1);
    chk("t1_release_aborts", 32'(bus.abort_cnt), 32'd0);

    // Both sources from reset: alternate 0,1,0,1; stall inside source 1's frame
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(100, who, c);
      chk("t2_order", 32'(who), 32'(i % 2));
      send_frame(who, 16, 1'b1, (i == 1) ? 5 : 1000, (i == 1) ? 5 : 0, 8'(i * 16));
      chk("t2_frame_cnt", 32'(bus.frame_cnt), 32'(i + 1));
      chk("t2_gnt_fall", 32'({bus.gnt1, bus.gnt0}), 32'd0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Watchdog (64-cycle limit instance); source 1 waits its turn
    bus_w.req0 = 1'b1;
    bus_w.req1 = 1'b1;
    bus_w.wr_en1 = 1'b1;
    bus_w.din1 = 9'h1FF;
    c = 0;
    while (bus_w.gnt0 !== 1'b1 && c < 40) begin step(); c++; end
    chk("wd_gnt0", 32'(bus_w.gnt0), 32'd1);
    bus_w.wr_en0 = 1'b1;
    bus_w.din0 = 9'h1C3;
    n = 1;
    while (n < 300) begin
      step();
      if (bus_w.gnt0 !== 1'b1) break;
      n++;
      if (n == 10) chk("wd_rdy1_ungranted", 32'(bus_w.rdy1), 32'd0);
    end
    chk("wd_gnt_cycles", 32'(n), 32'd64);
    chk("wd_term_wr", 32'(bus_w.phy_wr_en), 32'd1);
    chk("wd_term_din", 32'(bus_w.phy_din), 32'h000);
    chk("wd_abort_cnt", 32'(bus_w.abort_cnt), 32'd1);
    chk("wd_frame_cnt", 32'(bus_w.frame_cnt), 32'd0);
    bus_w.req0 = 1'b0;
    bus_w.wr_en0 = 1'b0;
    c = 0;
    while (bus_w.gnt1 !== 1'b1 && c < 60) begin step(); c++; end
    chk("wd_next_gnt1", 32'(bus_w.gnt1), 32'd1);
    chk("wd_ifg_spacing", 32'(c + 1 >= IFG + 2), 32'd1);
    bus_w.req1 = 1'b0;
    bus_w.wr_en1 = 1'b0;

    // req1 drops mid-frame -> abort; then drive abort_cnt into saturation
    bus.req1 = 1'b1;
    wait_gnt(100, who, c);
    chk("t4_who", 32'(who), 32'd1);
    send_frame(1, 10, 1'b0, 1000, 0, 8'h40);
    bus.req1 = 1'b0;
    step();
    chk("t4_term_wr", 32'(bus.phy_wr_en), 32'd1);
    chk("t4_term_din", 32'(bus.phy_din), 32'h000);
    chk("t4_gnt1", 32'(bus.gnt1), 32'd0);
    chk("t4_abort_cnt", 32'(bus.abort_cnt), 32'd1);
    chk("t4_frame_cnt", 32'(bus.frame_cnt), 32'd4);
    for (int k = 0; k < 299; k++) begin
      bus.req1 = 1'b1;
      wait_gnt(100, who, c);
      send_frame(1, 1, 1'b0, 1000, 0, 8'h11);
      bus.req1 = 1'b0;
      step();
      if (k == 253) chk("t4_abort_255", 32'(bus.abort_cnt), 32'd255);
    end
    chk("t4_abort_sat", 32'(bus.abort_cnt), 32'd255);
    chk("t4_frame_keep", 32'(bus.frame_cnt), 32'd4);

    // Mid-frame reset, then source 0 wins the first contended grant
    bus.req0 = 1'b1;
    wait_gnt(100, who, c);
    send_frame(who, 3, 1'b0, 1000, 0, 8'h70);
    bus.req1 = 1'b1;
    drive(who, 1'b1, 9'h1AA);
    rst = 1'b1;
    step();
    chk("t5_gnt0", 32'(bus.gnt0), 32'd0);
    chk("t5_gnt1", 32'(bus.gnt1), 32'd0);
    chk("t5_rdy0", 32'(bus.rdy0), 32'd0);
    chk("t5_rdy1", 32'(bus.rdy1), 32'd0);
    chk("t5_phy_din", 32'(bus.phy_din), 32'h000);
    chk("t5_phy_wr_en", 32'(bus.phy_wr_en), 32'd0);
    chk("t5_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("t5_abort_cnt", 32'(bus.abort_cnt), 32'd0);
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    rst = 1'b0;
    wait_gnt(20, who, c);
    chk("t5_first_gnt", 32'(who), 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
